// File: rtl/sram_dp_arb_pkg.sv
// Shared constants and types for the dual-port SRAM arbiter: master indices,
// word width and the read-response tag that follows a read grant by one cycle.
package sram_arb_pkg;

  localparam logic M_CPU  = 1'b0;
  localparam logic M_DMA  = 1'b1;
  localparam int   DATA_W = 32;

  typedef struct packed {
    logic pend;
    logic own;
  } rsp_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The pointer names the favoured requester
// and moves only when both request and a grant is actually issued.
module rr_arb2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       inhibit,
  output logic       win,
  output logic [1:0] gnt
);

  logic ptr;
  logic contest;

  always_comb begin
    contest = &req;
    win     = contest ? ptr : req[1];
    gnt     = 2'b00;
    if ((|req) && !inhibit)
      gnt = win ? 2'b10 : 2'b01;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      ptr <= 1'b0;
    else if (contest && !inhibit)
      ptr <= ~win;
  end

endmodule

// File: rtl/sram_dp_arb.sv
// Shares the SRAM read and write ports between two masters, stalls a read that
// hits the word being written this cycle, and routes read data to its owner.
module sram_dp_arb
  import sram_arb_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [AW-1:0]     m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [AW-1:0]     m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [AW-1:0]     ram_raddr,
  output logic              ram_ren,
  output logic [AW-1:0]     ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        ram_wen,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic [1:0] rd_req, wr_req, rd_gnt, wr_gnt;
  logic       rd_win, wr_win;
  logic [3:0] wr_strb;
  logic       collide;
  rsp_tag_t   rd_tag_p1;

  assign rd_req = {m1_req & ~m1_we, m0_req & ~m0_we};
  assign wr_req = {m1_req &  m1_we, m0_req &  m0_we};

  rr_arb2 u_wr_arb (
    .CLK     (CLK),
    .RST     (RST),
    .req     (wr_req),
    .inhibit (1'b0),
    .win     (wr_win),
    .gnt     (wr_gnt)
  );

  // A read only collides with a write that really modifies the same word.
  always_comb begin
    ram_waddr = wr_win ? m1_addr  : m0_addr;
    ram_wdata = wr_win ? m1_wdata : m0_wdata;
    wr_strb   = wr_win ? m1_wstrb : m0_wstrb;
    ram_wen   = (|wr_gnt) ? wr_strb : 4'b0000;
    ram_raddr = rd_win ? m1_addr : m0_addr;
    collide   = (|rd_req) && (|wr_gnt) && (ram_raddr == ram_waddr) && (|wr_strb);
  end

  rr_arb2 u_rd_arb (
    .CLK     (CLK),
    .RST     (RST),
    .req     (rd_req),
    .inhibit (collide),
    .win     (rd_win),
    .gnt     (rd_gnt)
  );

  assign ram_ren = |rd_gnt;
  assign m0_gnt  = rd_gnt[0] | wr_gnt[0];
  assign m1_gnt  = rd_gnt[1] | wr_gnt[1];

  // p0 -> p1: read grant becomes a response tag aligned with ram_rdata
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_tag_p1.pend <= 1'b0;
      rd_tag_p1.own  <= M_CPU;
    end else begin
      rd_tag_p1.pend <= ram_ren;
      rd_tag_p1.own  <= rd_win;
    end
  end

  assign m0_rvalid = rd_tag_p1.pend && (rd_tag_p1.own == M_CPU);
  assign m1_rvalid = rd_tag_p1.pend && (rd_tag_p1.own == M_DMA);
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;

endmodule

// File: tb/tb_sram_dp_arb.sv
// Directed bench for sram_dp_arb with a behavioural SRAM and a read-response
// scoreboard fed from a reference memory image.
module tb_sram_dp_arb;

  logic        CLK, RST;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [15:0] ram_raddr, ram_waddr;
  logic        ram_ren;
  logic [31:0] ram_wdata, ram_rdata;
  logic [3:0]  ram_wen;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        own;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] sram    [0:255];
  logic [31:0] ref_mem [0:255];

  sram_dp_arb #(.AW(16)) dut (
    .CLK(CLK), .RST(RST),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_raddr(ram_raddr), .ram_ren(ram_ren), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .ram_wen(ram_wen), .ram_rdata(ram_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural SRAM: registered read, byte-enable write, old data on same-address RDW.
  always @(posedge CLK) begin
    for (int b = 0; b < 4; b++)
      if (ram_wen[b]) sram[ram_waddr[7:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    if (ram_ren) ram_rdata <= sram[ram_raddr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ref_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[a[7:0]][b*8 +: 8] = d[b*8 +: 8];
  endtask

  // Response scoreboard: the response for a grant seen at one negedge is due at the next.
  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rsp_route", {30'b0, m1_rvalid, m0_rvalid}, e.own ? 32'd2 : 32'd1);
      check("rsp_data", e.own ? m1_rdata : m0_rdata, e.data);
    end else begin
      check("rsp_idle", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
    end
    if (m0_gnt && !m0_we) exp_q.push_back('{own: 1'b0, data: ref_mem[m0_addr[7:0]]});
    if (m1_gnt && !m1_we) exp_q.push_back('{own: 1'b1, data: ref_mem[m1_addr[7:0]]});
    if (m0_gnt && m0_we) ref_write(m0_addr, m0_wdata, m0_wstrb);
    if (m1_gnt && m1_we) ref_write(m1_addr, m1_wdata, m1_wstrb);
  end

  task automatic m0_set(input logic r, input logic w, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d; m0_wstrb = s;
  endtask

  task automatic m1_set(input logic r, input logic w, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d; m1_wstrb = s;
  endtask

  task automatic idle();
    m0_set(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    m1_set(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
  endtask

  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic g0, input logic g1);
    check(tag, {30'b0, m1_gnt, m0_gnt}, {30'b0, g1, g0});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i]    = 32'h0;
      ref_mem[i] = 32'h0;
    end
    ram_rdata = 32'h0;
    RST = 1'b1;
    idle();
    next();
    next();
    @(negedge CLK);
    check("rst_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
    check("rst_ren", {31'b0, ram_ren}, 32'd0);
    check("rst_wen", {28'b0, ram_wen}, 32'd0);
    next();
    RST = 1'b0;

    // Single read after a write
    m0_set(1'b1, 1'b1, 16'h0010, 32'h1234_5678, 4'hF);
    @(negedge CLK);
    chk_gnt("wr10_gnt", 1'b1, 1'b0);
    check("wr10_wen", {28'b0, ram_wen}, 32'hF);
    next();
    m0_set(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0);
    @(negedge CLK);
    chk_gnt("rd10_gnt", 1'b1, 1'b0);
    check("rd10_ren", {31'b0, ram_ren}, 32'd1);
    check("rd10_raddr", {16'b0, ram_raddr}, 32'h10);
    next();
    idle();
    @(negedge CLK);
    check("rd10_m0_rvalid", {31'b0, m0_rvalid}, 32'd1);
    check("rd10_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    next();

    // Contested writes to seed 0x20/0x30, then contested reads alternate
    m0_set(1'b1, 1'b1, 16'h0020, 32'hA0A0_A0A0, 4'hF);
    m1_set(1'b1, 1'b1, 16'h0030, 32'hB0B0_B0B0, 4'hF);
    @(negedge CLK);
    chk_gnt("wrc_a", 1'b1, 1'b0);
    next();
    m0_set(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    @(negedge CLK);
    chk_gnt("wrc_b", 1'b0, 1'b1);
    next();
    m0_set(1'b1, 1'b0, 16'h0020, 32'h0, 4'h0);
    m1_set(1'b1, 1'b0, 16'h0030, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk_gnt($sformatf("rdc_%0d", i), (i % 2) == 0, (i % 2) == 1);
      next();
    end
    idle();
    @(negedge CLK);
    next();

    // Collision: m1 read of the word m0 writes this cycle is delayed one cycle
    m0_set(1'b1, 1'b1, 16'h0040, 32'hAABB_CCDD, 4'hF);
    m1_set(1'b1, 1'b0, 16'h0040, 32'h0, 4'h0);
    @(negedge CLK);
    chk_gnt("col_a", 1'b1, 1'b0);
    check("col_ren", {31'b0, ram_ren}, 32'd0);
    next();
    m0_set(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    @(negedge CLK);
    chk_gnt("col_b", 1'b0, 1'b1);
    next();
    idle();
    @(negedge CLK);
    check("col_m1_rvalid", {31'b0, m1_rvalid}, 32'd1);
    next();

    // Byte strobes and the zero-strobe write
    m0_set(1'b1, 1'b1, 16'h0050, 32'hFFFF_FFFF, 4'hF);
    @(negedge CLK);
    chk_gnt("bs_full", 1'b1, 1'b0);
    next();
    m0_set(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    m1_set(1'b1, 1'b1, 16'h0050, 32'h0000_0012, 4'h1);
    @(negedge CLK);
    chk_gnt("bs_b0", 1'b0, 1'b1);
    check("bs_b0_wen", {28'b0, ram_wen}, 32'h1);
    next();
    m1_set(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    m0_set(1'b1, 1'b0, 16'h0050, 32'h0, 4'h0);
    @(negedge CLK);
    chk_gnt("bs_rd", 1'b1, 1'b0);
    next();
    m1_set(1'b1, 1'b1, 16'h0050, 32'hDEAD_BEEF, 4'h0);
    @(negedge CLK);
    chk_gnt("bs_zero", 1'b1, 1'b1);
    check("bs_zero_wen", {28'b0, ram_wen}, 32'h0);
    check("bs_zero_ren", {31'b0, ram_ren}, 32'd1);
    next();
    idle();
    @(negedge CLK);
    next();

    // Concurrent ports on different words
    m0_set(1'b1, 1'b1, 16'h0060, 32'h6666_6666, 4'hF);
    m1_set(1'b1, 1'b0, 16'h0070, 32'h0, 4'h0);
    @(negedge CLK);
    chk_gnt("cc_gnt", 1'b1, 1'b1);
    check("cc_waddr", {16'b0, ram_waddr}, 32'h60);
    check("cc_raddr", {16'b0, ram_raddr}, 32'h70);
    next();
    idle();
    @(negedge CLK);
    next();

    // Reset mid-read: contested grant to m0 moves the pointer to m1 first
    m0_set(1'b1, 1'b0, 16'h0020, 32'h0, 4'h0);
    m1_set(1'b1, 1'b0, 16'h0030, 32'h0, 4'h0);
    @(negedge CLK);
    chk_gnt("rr_pre", 1'b1, 1'b0);
    next();
    RST = 1'b1;
    exp_q.delete();
    idle();
    #1;
    check("rr_rvalid_now", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
    @(negedge CLK);
    next();
    RST = 1'b0;
    @(negedge CLK);
    check("rr_no_stray", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
    next();
    m0_set(1'b1, 1'b0, 16'h0020, 32'h0, 4'h0);
    m1_set(1'b1, 1'b0, 16'h0030, 32'h0, 4'h0);
    @(negedge CLK);
    chk_gnt("rr_post", 1'b1, 1'b0);
    next();
    idle();
    @(negedge CLK);
    next();
    next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
